// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared constants, FSM encoding and LED mapping for the column histogram path
package hist_pkg;
    localparam int COLS      = 80;
    localparam int ROWS      = 60;
    localparam int POS_W     = 7;
    localparam int CNT_W     = 6;
    localparam int DRAIN_CYC = 3;
    localparam int LED_N     = 8;
    localparam int LED_STEP  = COLS / LED_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } hist_state_e;

    // One-hot LED for a centroid column; each LED covers LED_STEP columns.
    function automatic logic [LED_N-1:0] led_for_centroid(input logic [POS_W-1:0] c);
        int unsigned idx;
        idx = 32'(c) / LED_STEP;
        if (idx > LED_N - 1) begin
            idx = LED_N - 1;
        end
        return LED_N'(1) << idx;
    endfunction
endpackage

// File: rtl/hist_col_counters.sv
// rtl/hist_col_counters.sv - per-column hit counters with combinational read and saturating write-back
module hist_col_counters
    import hist_pkg::*;
#(
    parameter int COLS_P  = hist_pkg::COLS,
    parameter int CNT_W_P = hist_pkg::CNT_W,
    parameter int POS_W_P = hist_pkg::POS_W
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic [POS_W_P-1:0] addr_i,
    input  logic               hit_i,
    input  logic               we_i,
    output logic [CNT_W_P-1:0] cnt_o
);
    logic [CNT_W_P-1:0] cnt_q [COLS_P];
    logic [CNT_W_P-1:0] rd;

    always_comb begin
        rd = cnt_q[addr_i];
        if (hit_i && (rd != {CNT_W_P{1'b1}})) begin
            cnt_o = rd + 1'b1;
        end else begin
            cnt_o = rd;
        end
    end

    // Clear wins over a same-cycle write so an aborted frame leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < COLS_P; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (we_i) begin
            cnt_q[addr_i] <= cnt_o;
        end
    end
endmodule

// File: rtl/hist_gen.sv
// rtl/hist_gen.sv - column histogram producer: frame FSM, position counters and two-stage update pipeline
module hist_gen
    import hist_pkg::*;
#(
    parameter int COLS  = hist_pkg::COLS,
    parameter int ROWS  = hist_pkg::ROWS,
    parameter int POS_W = hist_pkg::POS_W,
    parameter int CNT_W = hist_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_new,
    input  logic             px_valid,
    input  logic             px_hit,
    output logic [POS_W-1:0] px_pos_ret,
    output logic [CNT_W-1:0] reg_histograma,
    output logic             start,
    output logic             busy,
    output logic             frame_err
);
    localparam int ROW_W = $clog2(ROWS + 1);

    hist_state_e      state_q;
    logic [POS_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [1:0]       drain_q;
    logic             v1_q;
    logic             hit1_q;
    logic [POS_W-1:0] pos_q;
    logic [CNT_W-1:0] hist_q;
    logic             start_q;
    logic             busy_q;
    logic             err_q;

    logic             px_seen;
    logic             clr;
    logic             abort;
    logic             take_px;
    logic             last_px;
    logic [POS_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [CNT_W-1:0] upd;

    always_comb begin
        px_seen = (col_q != '0) || (row_q != '0);
        clr     = frame_new && (state_q != DRAIN);
        abort   = frame_new && (state_q == RUN) && px_seen;
        take_px = px_valid && ((state_q == RUN) || ((state_q == IDLE) && frame_new));
        cur_col = frame_new ? '0 : col_q;
        cur_row = frame_new ? '0 : row_q;
        last_px = take_px && (cur_col == POS_W'(COLS - 1)) && (cur_row == ROW_W'(ROWS - 1));
    end

    hist_col_counters #(
        .COLS_P (COLS),
        .CNT_W_P(CNT_W),
        .POS_W_P(POS_W)
    ) u_counters (
        .clk    (clk),
        .rst_i  (rst),
        .clear_i(clr),
        .addr_i (pos_q),
        .hit_i  (hit1_q),
        .we_i   (v1_q),
        .cnt_o  (upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            v1_q    <= 1'b0;
            hit1_q  <= 1'b0;
            pos_q   <= '0;
            hist_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            v1_q    <= take_px;
            hit1_q  <= px_hit;
            // Downstream keeps a running max, so non-update cycles must present zero.
            hist_q  <= (v1_q && !clr) ? upd : '0;
            if (take_px) begin
                pos_q <= cur_col;
            end
            if (last_px) begin
                col_q <= '0;
                row_q <= '0;
            end else if (take_px) begin
                if (cur_col == POS_W'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= cur_row + 1'b1;
                end else begin
                    col_q <= cur_col + 1'b1;
                    row_q <= cur_row;
                end
            end else if (clr) begin
                col_q <= '0;
                row_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (frame_new) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        err_q <= 1'b1;
                    end
                    if (last_px) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    if (frame_new || px_valid) begin
                        err_q <= 1'b1;
                    end
                    if (drain_q == 2'(DRAIN_CYC - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                        if (drain_q == 2'(DRAIN_CYC - 2)) begin
                            start_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign px_pos_ret     = pos_q;
    assign reg_histograma = hist_q;
    assign start          = start_q;
    assign busy           = busy_q;
    assign frame_err      = err_q;
endmodule

// File: tb/tb_hist_gen.sv
// tb/tb_hist_gen.sv - scoreboard bench for hist_gen
module tb_hist_gen;
    import hist_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_new;
    logic             px_valid;
    logic             px_hit;
    logic [POS_W-1:0] px_pos_ret;
    logic [CNT_W-1:0] reg_histograma;
    logic             start;
    logic             busy;
    logic             frame_err;

    always #5 clk = ~clk;

    hist_gen dut (
        .clk           (clk),
        .rst           (rst),
        .frame_new     (frame_new),
        .px_valid      (px_valid),
        .px_hit        (px_hit),
        .px_pos_ret    (px_pos_ret),
        .reg_histograma(reg_histograma),
        .start         (start),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    exp_t pos_exp[$];
    exp_t cnt_exp[$];
    int   start_exp[$];
    int   err_exp[$];
    int   model[COLS];
    int   maxh[COLS];
    int   col_m = 0;
    int   row_m = 0;
    int   m_state = 0;
    int   drain_end = 0;
    int   n_start = 0;
    int   prev_pos = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Scoreboard side: every cycle compares against what the driver queued for it.
    always @(negedge clk) begin
        if (mon_on) begin
            if (pos_exp.size() > 0 && pos_exp[0].cyc == cyc) begin
                check_val("pos", int'(px_pos_ret), pos_exp[0].val);
                void'(pos_exp.pop_front());
            end
            if (cnt_exp.size() > 0 && cnt_exp[0].cyc == cyc) begin
                check_val("hist", int'(reg_histograma), cnt_exp[0].val);
                void'(cnt_exp.pop_front());
            end else begin
                check_val("hist_gap_zero", int'(reg_histograma), 0);
            end
            if (start_exp.size() > 0 && start_exp[0] == cyc) begin
                check_val("start", int'(start), 1);
                void'(start_exp.pop_front());
            end else begin
                check_val("start_quiet", int'(start), 0);
            end
            if (err_exp.size() > 0 && err_exp[0] == cyc) begin
                check_val("frame_err", int'(frame_err), 1);
                void'(err_exp.pop_front());
            end else begin
                check_val("frame_err_quiet", int'(frame_err), 0);
            end
            if (start) n_start++;
            if (prev_pos < COLS && int'(reg_histograma) > maxh[prev_pos]) maxh[prev_pos] = int'(reg_histograma);
            prev_pos = int'(px_pos_ret);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < COLS; i++) model[i] = 0;
        col_m = 0;
        row_m = 0;
    endtask

    task automatic clear_max();
        for (int i = 0; i < COLS; i++) maxh[i] = 0;
    endtask

    // Drive one cycle and queue the outputs it should cause.
    task automatic step(input bit fn, input bit v, input bit h);
        int n;
        n = cyc;
        if (m_state == 2 && n > drain_end) m_state = 0;
        frame_new = fn;
        px_valid  = v;
        px_hit    = h;
        if (m_state == 2) begin
            if (fn || v) err_exp.push_back(n + 1);
        end else if (fn) begin
            if (m_state == 1 && (col_m != 0 || row_m != 0)) begin
                err_exp.push_back(n + 1);
                while (cnt_exp.size() > 0 && cnt_exp[$].cyc > n) void'(cnt_exp.pop_back());
            end
            clear_model();
            m_state = 1;
        end
        if (m_state == 1 && v) begin
            if (h && model[col_m] < (1 << CNT_W) - 1) model[col_m]++;
            pos_exp.push_back('{n + 1, col_m});
            cnt_exp.push_back('{n + 2, model[col_m]});
            col_m++;
            if (col_m == COLS) begin
                col_m = 0;
                row_m++;
            end
            if (row_m == ROWS) begin
                row_m     = 0;
                m_state   = 2;
                drain_end = n + DRAIN_CYC;
                start_exp.push_back(n + DRAIN_CYC);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_for(input int k);
        int n;
        n = cyc;
        while (pos_exp.size() > 0 && pos_exp[$].cyc > n) void'(pos_exp.pop_back());
        while (cnt_exp.size() > 0 && cnt_exp[$].cyc > n) void'(cnt_exp.pop_back());
        while (start_exp.size() > 0 && start_exp[$] > n) void'(start_exp.pop_back());
        while (err_exp.size() > 0 && err_exp[$] > n) void'(err_exp.pop_back());
        clear_model();
        m_state   = 0;
        rst       = 1'b1;
        frame_new = 1'b0;
        px_valid  = 1'b0;
        px_hit    = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    function automatic bit hit_of(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return (k % COLS == 40) && (k / COLS < 30);
    endfunction

    // mode 0: all hits, mode 1: column 40 rows 0-29; stop_after<0 means full frame.
    task automatic run_frame(input int mode, input int gap_pct, input int stop_after);
        int k;
        bit v;
        k = 0;
        while (k < COLS * ROWS && k != stop_after) begin
            v = (k == 0) || ($urandom_range(99) >= gap_pct);
            step(k == 0, v, v && hit_of(mode, k));
            if (v) k++;
        end
    endtask

    function automatic int centroid();
        longint s;
        longint w;
        s = 0;
        w = 0;
        for (int i = 0; i < COLS; i++) begin
            s += maxh[i];
            w += longint'(i) * maxh[i];
        end
        return (s == 0) ? -1 : int'(w / s);
    endfunction

    initial begin
        int starts0;
        logic [LED_N-1:0] leds;
        logic [LED_N-1:0] leds_want;
        rst       = 1'b1;
        frame_new = 1'b0;
        px_valid  = 1'b0;
        px_hit    = 1'b0;
        clear_model();
        clear_max();
        repeat (5) @(posedge clk);
        #1;
        mon_on = 1'b1;
        check_val("rst_pos", int'(px_pos_ret), 0);
        check_val("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_pos", int'(px_pos_ret), 0);

        // Silent restart, then all-hit frame
        step(1'b1, 1'b0, 1'b0);
        check_val("busy_rise", int'(busy), 1);
        step(1'b1, 1'b0, 1'b0);
        clear_max();
        starts0 = n_start;
        run_frame(0, 0, -1);
        idle(2);
        check_val("busy_at_start", int'(busy), 1);
        idle(1);
        check_val("busy_fall", int'(busy), 0);
        idle(3);
        check_val("s2_start_count", n_start - starts0, 1);
        check_val("s2_col0", maxh[0], 60);
        check_val("s2_col79", maxh[79], 60);
        check_val("s2_centroid", centroid(), 39);
        check_val("pos_hold", int'(px_pos_ret), COLS - 1);

        // Single column, back-to-back then with gaps
        for (int g = 0; g < 2; g++) begin
            clear_max();
            run_frame(1, g * 50, -1);
            idle(6);
            check_val("s3_col40", maxh[40], 30);
            check_val("s3_col39", maxh[39], 0);
            check_val("s3_centroid", centroid(), 40);
            leds      = led_for_centroid(POS_W'(centroid()));
            leds_want = 8'b0001_0000;
            check_val("s3_leds", int'(leds), int'(leds_want));
        end

        // Abort after 100 pixels, then a clean frame
        starts0 = n_start;
        run_frame(0, 0, 100);
        clear_max();
        run_frame(0, 0, -1);
        idle(6);
        check_val("s5_start_count", n_start - starts0, 1);
        check_val("s5_col0", maxh[0], 60);
        check_val("s5_col19", maxh[19], 60);

        // frame_new and px_valid during DRAIN
        starts0 = n_start;
        run_frame(0, 0, -1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(6);
        check_val("s6_start_count", n_start - starts0, 1);
        check_val("s6_busy", int'(busy), 0);

        // Reset in the middle of a frame
        starts0 = n_start;
        run_frame(0, 0, 500);
        reset_for(2);
        check_val("s6_rst_pos", int'(px_pos_ret), 0);
        check_val("s6_rst_busy", int'(busy), 0);
        idle(8);
        check_val("s6_rst_nostart", n_start - starts0, 0);

        check_val("left_pos", pos_exp.size(), 0);
        check_val("left_cnt", cnt_exp.size(), 0);
        check_val("left_start", start_exp.size(), 0);
        check_val("left_err", err_exp.size(), 0);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hist_gen.md
# hist_gen

Column-histogram producer for the colour-filter centroid path. Scans a filtered 80×60 binary pixel stream, keeps a per-column hit count, and streams each updated count with its column index. The stream format is exactly what the centroid calculator consumes: index first, count one cycle later, then a `start` pulse once the frame is complete. It sits between the pixel colour filter and the centroid/LED block.

## Interface

**Parameters**
- `COLS`, 80: columns per frame.
- `ROWS`, 60: rows per frame.
- `POS_W`, 7: column index width.
- `CNT_W`, 6: per-column count width.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `frame_new` in 1: one-cycle pulse marking a new frame. A pixel in the same cycle is pixel (0,0).
- `px_valid` in 1: pixel strobe.
- `px_hit` in 1: filter result for the pixel; 1 means the colour matched.
- `px_pos_ret` out POS_W: column index of the update in flight.
- `reg_histograma` out CNT_W: updated count for the column given by `px_pos_ret` in the previous cycle.
- `start` out 1: one-cycle pulse; the frame histogram is complete.
- `busy` out 1: high in RUN or DRAIN.
- `frame_err` out 1: one-cycle pulse on a protocol violation or an aborted frame.

## Operation

**States**
- IDLE: `px_valid` is ignored. `frame_new` clears all counters, zeroes `col`/`row`, and enters RUN.
- RUN: each accepted pixel advances `col` from 0 to COLS-1. When `col` wraps, `row` increments. The pixel (COLS-1, ROWS-1) moves the block to DRAIN.
- DRAIN: a fixed 3-cycle counter runs, then `start` is emitted and the block returns to IDLE.

**Pipeline**
- Stage 1 registers `col` and `hit` into `px_pos_ret` and `v1`.
- Stage 2 reads `count[px_pos_ret]` and computes `count + hit`, saturating at 2^CNT_W-1. It writes the result back and drives it on `reg_histograma`.
- A read-modify-write hazard is impossible because the same column repeats no sooner than COLS accepted pixels later.
- Every update is emitted, including `hit`=0 updates, which re-send the current count.
- `reg_histograma` is forced to 0 in every cycle that does not carry a valid stage-2 update. The downstream block takes a running max every cycle, so a stale nonzero value is forbidden.
- `px_pos_ret` holds its last value when idle.
- Counters are not cleared at `start`; they are cleared only by `frame_new` or `rst`.

**Boundary conditions**
- `frame_new` in RUN after at least one pixel: abort. Pulse `frame_err`, flush the stage valids (no further nonzero output), clear the counters, and restart RUN. No `start` is issued for the aborted frame.
- `frame_new` in RUN before any pixel: restart silently.
- `frame_new` or `px_valid` during DRAIN: ignored, and `frame_err` pulses. Upstream guarantees at least 3 cycles of blanking.
- `px_valid` in IDLE: ignored, no error (blanking).
- Gaps in `px_valid`: allowed anywhere in RUN.
- `rst` at any point: return to IDLE and zero everything. The in-flight frame is dropped and no `start` is issued.

**Reset values:** `px_pos_ret`=0, `reg_histograma`=0, `start`=0, `busy`=0, `frame_err`=0, all counters 0, `col`=`row`=0, state IDLE.

## Timing

- For a pixel accepted at the end of cycle N at column c:
  - `px_pos_ret` = c during cycle N+1.
  - `reg_histograma` = the new count during cycle N+2.
- Last pixel accepted at cycle N: `start` is high during cycle N+3 only. This guarantees the final count is captured downstream before the snapshot/clear that `start` triggers there.
- `busy` rises the cycle after `frame_new` and falls the cycle after `start`.
- `frame_err` is high the cycle after the offending input.
- Throughput is one pixel per cycle, with no back-pressure.

## Structure

**Shared package `hist_pkg`:**
- Constants `COLS`, `ROWS`, `POS_W`, `CNT_W`.
- State encoding IDLE=0, RUN=1, DRAIN=2.
- `DRAIN_CYC`=3.
- The `centroid`/LED thresholds belong here too, for reuse by the consumer.

**Sub-module `hist_col_counters`:**
- Holds the COLS×CNT_W register array.
- Synchronous clear.
- One combinational read port and one write port, with saturating increment.
- The top level keeps the FSM, position counters and output pipeline.

## Test plan

1. Reset held 5 cycles, then released → all outputs 0, `busy`=0. A `px_valid` in IDLE produces no output.
2. `frame_new` then 4800 back-to-back pixels with `hit`=1 → the last row of updates shows `reg_histograma`=60 for every column 0–79. `start` pulses exactly once, 3 cycles after the last pixel. The model centroid is 39.
3. Hits only at column 40, rows 0–29 → column 40 update values rise 1..30, then repeat 30. All other columns output 0. The consumer model yields centroid 40 and LEDs `8'b00010000`.
4. Same frame as scenario 3 with random `px_valid` gaps (≈50% duty) → identical count sequence, and `reg_histograma`=0 in every gap cycle.
5. `frame_new` after 100 pixels, then a full all-hit frame → `frame_err` pulses once, no `start` for the aborted frame, and the final counts are 60, not 62.
6. `frame_new` in DRAIN → ignored, `frame_err`=1 for one cycle, `start` still issued on time. Separately, `rst` mid-RUN → IDLE, outputs 0, no `start`.
